// File: rtl/dircc_rts_arbiter.sv
// Ready-to-send handler: registers per-port RTS flags and offers one pending port
// per transaction to the send engine, round-robin, with a saturating completion count.
module dircc_rts_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int PORT_IDX_WIDTH    = $clog2(NUM_PORTS),
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         state_valid,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         dev_running,
  input  logic [NUM_PORTS-1:0]         rts_flags,
  output logic [NUM_PORTS-1:0]         rts_ready,
  output logic                         send_valid,
  output logic [PORT_IDX_WIDTH-1:0]    send_port,
  output logic [ADDRESS_MEM_WIDTH-1:0] send_address,
  input  logic                         send_ready,
  input  logic                         send_done,
  output logic                         busy,
  output logic [COUNT_WIDTH-1:0]       sent_count,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_PORTS-1:0]         rts_ready_q, rts_ready_d;
  logic                         send_valid_q, send_valid_d;
  logic [PORT_IDX_WIDTH-1:0]    send_port_q, send_port_d;
  logic [ADDRESS_MEM_WIDTH-1:0] send_address_q, send_address_d;
  logic [PORT_IDX_WIDTH-1:0]    last_grant_q, last_grant_d;
  logic [COUNT_WIDTH-1:0]       sent_count_q, sent_count_d;

  logic                         start;
  logic                         found;
  logic [PORT_IDX_WIDTH-1:0]    winner;
  logic [PORT_IDX_WIDTH-1:0]    idx;

  assign start = (state_q == IDLE) && state_valid && dev_running && (|rts_flags);

  // Search starts one past the last grant and wraps, so a lone flag always wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_IDX_WIDTH'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!found && rts_flags[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)      state_d = OFFER;
      OFFER:     if (send_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (send_done)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    state_dbg = state_q;
  end

  // Handshake: an offer is raised with send_valid and held (port and address frozen)
  // until the cycle send_valid && send_ready is sampled; it is never withdrawn early.
  always_comb begin
    rts_ready_d    = state_valid ? (rts_flags & {NUM_PORTS{dev_running}}) : rts_ready_q;
    send_valid_d   = send_valid_q;
    send_port_d    = send_port_q;
    send_address_d = send_address_q;
    last_grant_d   = last_grant_q;
    sent_count_d   = sent_count_q;
    if (start) begin
      send_valid_d   = 1'b1;
      send_port_d    = winner;
      send_address_d = address;
    end
    if (state_q == OFFER && send_valid_q && send_ready) begin
      send_valid_d = 1'b0;
      last_grant_d = send_port_q;
    end
    if (state_q == WAIT_DONE && send_done && sent_count_q != {COUNT_WIDTH{1'b1}}) begin
      sent_count_d = sent_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rts_ready_q    <= '0;
      send_valid_q   <= 1'b0;
      send_port_q    <= '0;
      send_address_q <= '0;
      last_grant_q   <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
      sent_count_q   <= '0;
    end else begin
      rts_ready_q    <= rts_ready_d;
      send_valid_q   <= send_valid_d;
      send_port_q    <= send_port_d;
      send_address_q <= send_address_d;
      last_grant_q   <= last_grant_d;
      sent_count_q   <= sent_count_d;
    end
  end

  assign rts_ready    = rts_ready_q;
  assign send_valid   = send_valid_q;
  assign send_port    = send_port_q;
  assign send_address = send_address_q;
  assign sent_count   = sent_count_q;

endmodule

// File: tb/tb_dircc_rts_arbiter.sv
// Directed bench for dircc_rts_arbiter: round-robin grants, offer hold, count
// saturation (4-bit counter build) and asynchronous reset mid-transaction.
module tb_dircc_rts_arbiter;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          state_valid = 1'b0;
  logic [AW-1:0] address = '0;
  logic          dev_running = 1'b0;
  logic [NP-1:0] rts_flags = '0;
  logic          send_ready = 1'b0;
  logic          send_done = 1'b0;
  logic [NP-1:0] rts_ready;
  logic          send_valid;
  logic [PW-1:0] send_port;
  logic [AW-1:0] send_address;
  logic          busy;
  logic [CW-1:0] sent_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  dircc_rts_arbiter #(
    .NUM_PORTS(NP),
    .PORT_IDX_WIDTH(PW),
    .ADDRESS_MEM_WIDTH(AW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .state_valid(state_valid),
    .address(address),
    .dev_running(dev_running),
    .rts_flags(rts_flags),
    .rts_ready(rts_ready),
    .send_valid(send_valid),
    .send_port(send_port),
    .send_address(send_address),
    .send_ready(send_ready),
    .send_done(send_done),
    .busy(busy),
    .sent_count(sent_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [AW-1:0] addr, input logic run, input logic [NP-1:0] flags);
    state_valid = 1'b1;
    address     = addr;
    dev_running = run;
    rts_flags   = flags;
    step();
    state_valid = 1'b0;
  endtask

  // One full transaction with send_ready already high: offer, accept, done.
  task automatic do_txn(input logic [AW-1:0] addr, input logic [NP-1:0] flags, input int port);
    present(addr, 1'b1, flags);
    check("offer_valid", 32'(send_valid), 32'd1);
    check("offer_port", 32'(send_port), 32'(port));
    check("offer_addr", send_address, addr);
    step();
    check("accept_valid", 32'(send_valid), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    exp_count = (exp_count < 15) ? exp_count + 1 : 15;
    check("done_idle", 32'(busy), 32'd0);
    check("done_count", 32'(sent_count), 32'(exp_count));
  endtask

  initial begin
    step();
    step();
    check("rst_rts_ready", 32'(rts_ready), 32'd0);
    check("rst_send_valid", 32'(send_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(sent_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    step();

    // Test 1: first grant is port 0 and ready-already-high gives a 1-cycle offer.
    send_ready = 1'b1;
    present(32'h10, 1'b1, 4'b0101);
    check("t1_rts_ready", 32'(rts_ready), 32'h5);
    check("t1_valid", 32'(send_valid), 32'd1);
    check("t1_port", 32'(send_port), 32'd0);
    check("t1_addr", send_address, 32'h10);
    step();
    check("t1_valid_drop", 32'(send_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state", 32'(state_dbg), 32'd2);
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    exp_count = 1;
    check("t1_count", 32'(sent_count), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // Test 2: alternating grants 2, 0, 2 on flags 0101.
    do_txn(32'h11, 4'b0101, 2);
    do_txn(32'h12, 4'b0101, 0);
    do_txn(32'h13, 4'b0101, 2);
    check("t2_count4", 32'(sent_count), 32'd4);

    // Test 3: not running gives no offer and cleared rts_ready.
    present(32'h30, 1'b0, 4'b1111);
    check("t3_rts_ready", 32'(rts_ready), 32'h0);
    check("t3_valid", 32'(send_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    step();
    check("t3_valid_later", 32'(send_valid), 32'd0);
    check("t3_busy_later", 32'(busy), 32'd0);
    do_txn(32'h31, 4'b1000, 3);
    check("t3_rts_hold", 32'(rts_ready), 32'h8);

    // Test 4: offer held under back-pressure; late state_valid updates rts_ready only.
    send_ready = 1'b0;
    present(32'h40, 1'b1, 4'b0110);
    check("t4_port", 32'(send_port), 32'd1);
    check("t4_valid", 32'(send_valid), 32'd1);
    step();
    step();
    present(32'h20, 1'b1, 4'b0010);
    check("t4_rts_ready", 32'(rts_ready), 32'h2);
    check("t4_port_held", 32'(send_port), 32'd1);
    check("t4_addr_held", send_address, 32'h40);
    check("t4_valid_held", 32'(send_valid), 32'd1);
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    check("t4_stray_done", 32'(sent_count), 32'd5);
    check("t4_state_offer", 32'(state_dbg), 32'd1);
    step();
    check("t4_valid_5cyc", 32'(send_valid), 32'd1);
    send_ready = 1'b1;
    step();
    check("t4_accept", 32'(send_valid), 32'd0);
    check("t4_state_wait", 32'(state_dbg), 32'd2);
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    exp_count = 6;
    check("t4_count", 32'(sent_count), 32'd6);

    // Test 5: eleven more transactions saturate the 4-bit counter at 15.
    for (int k = 0; k < 11; k++) begin
      do_txn(32'h100 + 32'(k), 4'b1111, (2 + k) % 4);
    end
    check("t5_saturated", 32'(sent_count), 32'd15);
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    check("t5_idle_done", 32'(sent_count), 32'd15);

    // Test 6: asynchronous reset in OFFER, then in WAIT_DONE.
    send_ready = 1'b0;
    present(32'h60, 1'b1, 4'b0100);
    check("t6_offer_port", 32'(send_port), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_offer_rst_valid", 32'(send_valid), 32'd0);
    check("t6_offer_rst_busy", 32'(busy), 32'd0);
    check("t6_offer_rst_count", 32'(sent_count), 32'd0);
    step();
    reset_n = 1'b1;
    send_ready = 1'b1;
    exp_count = 0;
    present(32'h61, 1'b1, 4'b0100);
    step();
    check("t6_in_wait", 32'(state_dbg), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(send_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rts_ready", 32'(rts_ready), 32'h0);
    check("t6_rst_count", 32'(sent_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    do_txn(32'h70, 4'b1111, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
